store_rmw_ctrl: RTL and testbench
=================================

STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum wait cycles in READ or WRITE before abort; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  store request present.
REQ-005 SHALL have port req_ready  output  1  controller idle; request accepted when req_valid and req_ready are both 1.
REQ-006 SHALL have port Addr  input  32  store byte address.
REQ-007 SHALL have port rd2  input  32  store data, lane-aligned; byte k is rd2[8k+7:8k].
REQ-008 SHALL have port StoreType  input  2  00 word, 01 byte, 1x half; bit 1 has priority.
REQ-009 SHALL have port mem_addr  output  32  word-aligned address {Addr[31:2],2'b00}, registered at accept.
REQ-010 SHALL have port mem_re  output  1  read request, held until mem_rvalid.
REQ-011 SHALL have port mem_rdata  input  32  read word, valid when mem_rvalid=1.
REQ-012 SHALL have port mem_rvalid  input  1  read data valid.
REQ-013 SHALL have port mem_we  output  1  write request, held until mem_ack.
REQ-014 SHALL have port mem_wdata  output  32  registered merged write word.
REQ-015 SHALL have port mem_ack  input  1  write accepted.
REQ-016 SHALL have port done  output  1  one-cycle pulse: store completed.
REQ-017 SHALL have port err  output  1  one-cycle pulse: store aborted, no write issued.

Function
REQ-018 SHALL implement states IDLE, READ, MERGE, WRITE; req_ready=1 only in IDLE.
REQ-019 On accept, SHALL latch Addr[1:0], rd2, StoreType and mem_addr; word goes IDLE->WRITE with mem_wdata=rd2; byte/half goes IDLE->READ.
REQ-020 In READ, mem_re=1; on mem_rvalid, SHALL capture mem_rdata and go to MERGE.
REQ-021 In MERGE (exactly one cycle), SHALL register mem_wdata = captured word with the addressed lane replaced from latched rd2: byte lane Addr[1:0]; half lane Addr[1] (bits 15:0 or 31:16); then go to WRITE.
REQ-022 In WRITE, mem_we=1; when mem_ack=1, done=1 in that same cycle and next state is IDLE.
REQ-023 Minimum latency (accept cycle T, zero-wait memory): word done at T+1; byte/half done at T+3.
REQ-024 An 8-bit wait counter SHALL clear on every state entry and increment each cycle in READ/WRITE; at count==TIMEOUT without rvalid/ack, err=1 that cycle and next state is IDLE.
REQ-025 If mem_rvalid or mem_ack coincides with count==TIMEOUT, the handshake SHALL win; err=0.
REQ-026 mem_rvalid outside READ and mem_ack outside WRITE SHALL be ignored.
REQ-027 mem_re and mem_we SHALL never both be 1.

Reset
REQ-028 On a clock edge with reset=1, SHALL enter IDLE and clear the counter; mem_re=0, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0; req_ready=1 after the edge.
REQ-029 Reset mid-READ/MERGE/WRITE SHALL abandon the store with no done or err pulse; a request presented while reset=1 SHALL NOT be accepted.

Configuration
REQ-030 With MISALIGN_TRAP_EN defined, a request with half and Addr[0]=1, or word and Addr[1:0]!=0, SHALL be accepted, stay in IDLE, and pulse err in the cycle after accept with no memory access.
REQ-031 Without MISALIGN_TRAP_EN, word stores SHALL ignore Addr[1:0], and half stores SHALL ignore Addr[0] and select the lane by Addr[1].

Verification
REQ-032 Byte store: Addr=0x00001001, rd2=0xFFFFAAFF, StoreType=01, mem_rdata=0x11223344 -> write 0x1122AA44 to 0x00001000; done at T+3.
REQ-033 Half store: Addr=0x00002002, rd2=0xBEEF0000, StoreType=10, mem_rdata=0x11223344 -> write 0xBEEF3344 to 0x00002000.
REQ-034 Word store: Addr=0x00003000, rd2=0xDEADBEEF, StoreType=00 -> mem_re never asserted; write 0xDEADBEEF; done at T+1.
REQ-035 Timeout: TIMEOUT=4, byte store, mem_rvalid held 0 -> err pulse after 4 READ cycles, mem_we never asserted, req_ready=1 next cycle.
REQ-036 Reset in READ: assert reset for one cycle -> mem_re=0 and req_ready=1 after the edge; no done or err; a subsequent word store completes normally.
REQ-037 With MISALIGN_TRAP_EN: half store at Addr=0x00000003 -> err at T+1, no mem_re or mem_we; same stimulus without the macro -> upper-half merge written to 0x00000000.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write controller for byte/half/word stores onto a word-wide memory port.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests are accepted and rejected with an err pulse.
module store_rmw_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] Addr,
  input  logic [31:0] rd2,
  input  logic [1:0]  StoreType,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [1:0]  lane_reg;
  logic [1:0]  type_reg;
  logic [31:0] data_reg;
  logic [31:0] rdata_reg;
  logic        trap_err_reg;

  logic        accept;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  byte_en;
  logic [31:0] merged;

  assign req_ready   = (state_reg == IDLE) && !reset;
  assign accept      = req_valid && req_ready;
  assign timeout_hit = (wait_cnt_reg == TIMEOUT_CNT);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (StoreType[1] && Addr[0]) ||
                      ((StoreType == 2'b00) && (Addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lanes taken from the store data; the rest come from the word read back.
  always_comb begin
    byte_en = 4'b1111;
    if (type_reg[1]) begin
      byte_en = lane_reg[1] ? 4'b1100 : 4'b0011;
    end else if (type_reg[0]) begin
      byte_en = 4'b0001 << lane_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = byte_en[gi] ? data_reg[8*gi +: 8] : rdata_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && !misaligned) begin
          state_next = (StoreType == 2'b00) ? WRITE : READ;
        end
      end
      READ: begin
        if (mem_rvalid) begin
          state_next = MERGE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      MERGE:   state_next = WRITE;
      WRITE: begin
        if (mem_ack || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change so each wait phase gets its own budget.
  always_comb begin
    wait_cnt_next = 8'd0;
    if ((state_next == state_reg) && ((state_reg == READ) || (state_reg == WRITE))) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
  end

  assign mem_re = (state_reg == READ);
  assign mem_we = (state_reg == WRITE);
  assign done   = !reset && (state_reg == WRITE) && mem_ack;
  assign err    = !reset && (trap_err_reg ||
                  (timeout_hit && (((state_reg == READ) && !mem_rvalid) ||
                                   ((state_reg == WRITE) && !mem_ack))));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 8'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      lane_reg     <= 2'd0;
      type_reg     <= 2'd0;
      data_reg     <= 32'd0;
      rdata_reg    <= 32'd0;
      trap_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      trap_err_reg <= accept && misaligned;
      if (accept) begin
        mem_addr <= {Addr[31:2], 2'b00};
        lane_reg <= Addr[1:0];
        type_reg <= StoreType;
        data_reg <= rd2;
        if (StoreType == 2'b00) begin
          mem_wdata <= rd2;
        end
      end
      if ((state_reg == READ) && mem_rvalid) begin
        rdata_reg <= mem_rdata;
      end
      if (state_reg == MERGE) begin
        mem_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Self-checking bench for store_rmw_ctrl: directed table, hand-written corner sequences,
// and randomized stores against a cycle-count/merge reference model.
module tb_store_rmw_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] Addr;
  logic [31:0] rd2;
  logic [1:0]  StoreType;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  store_rmw_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .Addr(Addr), .rd2(rd2), .StoreType(StoreType), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // d: READ cycles before rvalid, e: WRITE cycles before ack (counted from state entry).
  // exp_done / exp_err: cycle after accept (1 = T+1), 0 = never.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d32;
    logic [1:0]  st;
    logic [31:0] rdata;
    int          d;
    int          e;
    int          exp_done;
    int          exp_err;
    int          exp_re;
    bit          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: outcome from the protocol timing rules and lane arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [31:0] mask;
    logic [31:0] ones;
    bit          trap;
    int          ws;
    r    = v;
    ones = 32'hFFFF_FFFF;
    if (v.st[1])      mask = (ones >> 16) << (16 * int'(v.a[1]));
    else if (v.st[0]) mask = (ones >> 24) << (8 * int'(v.a[1:0]));
    else              mask = ones;
    r.exp_wdata = (v.rdata & ~mask) | (v.d32 & mask);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (v.st[1] && v.a[0]) || ((v.st == 2'b00) && (v.a[1:0] != 2'b00));
`endif
    r.exp_done = 0; r.exp_err = 0; r.exp_re = 0; r.exp_wr = 1'b0;
    if (trap) begin
      r.exp_err = 1;
    end else begin
      ws = 1;
      if (v.st != 2'b00) begin
        if (v.d > TO) begin
          r.exp_re  = TO + 1;
          r.exp_err = 1 + TO;
          return r;
        end
        r.exp_re = v.d + 1;
        ws = 3 + v.d;
      end
      r.exp_wr = 1'b1;
      if (v.e <= TO) r.exp_done = ws + v.e;
      else           r.exp_err  = ws + TO;
    end
    return r;
  endfunction

  task automatic run_check(input vec_t v, input string tag);
    int          done_c, err_c, re_c, we_c;
    bit          both, ma_seen, ended;
    logic [31:0] wd, ma;
    done_c = 0; err_c = 0; re_c = 0; we_c = 0;
    both = 1'b0; ma_seen = 1'b0; ended = 1'b0; wd = 32'd0; ma = 32'd0;
    txn++;
    @(negedge clk);
    req_valid = 1'b1; Addr = v.a; rd2 = v.d32; StoreType = v.st;
    mem_rdata = v.rdata; mem_rvalid = 1'b0; mem_ack = 1'b0;
    #1 chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      mem_rvalid = mem_re && (re_c == v.d);
      mem_ack    = mem_we && (we_c == v.e);
      #1;
      if (mem_re && mem_we) both = 1'b1;
      if ((mem_re || mem_we) && !ma_seen) begin ma = mem_addr; ma_seen = 1'b1; end
      if (mem_re) re_c++;
      if (mem_we) begin we_c++; wd = mem_wdata; end
      if (done && done_c == 0) done_c = cyc;
      if (err && err_c == 0) err_c = cyc;
      if (done || err) begin ended = 1'b1; break; end
      @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_ack = 1'b0;
    #1;
    chk({tag, " done_cycle"}, 32'(done_c), 32'(v.exp_done));
    chk({tag, " err_cycle"},  32'(err_c),  32'(v.exp_err));
    chk({tag, " re_cycles"},  32'(re_c),   32'(v.exp_re));
    chk({tag, " we_seen"},    32'(we_c > 0), 32'(v.exp_wr));
    chk({tag, " re_we_both"}, 32'(both),   32'd0);
    if (v.exp_wr) chk({tag, " wdata"}, wd, v.exp_wdata);
    if (v.exp_wr || v.exp_re > 0) chk({tag, " mem_addr"}, ma, {v.a[31:2], 2'b00});
    chk({tag, " ready_after"}, 32'(req_ready && !mem_re && !mem_we), 32'd1);
    $display("txn %0d %s st=%0d addr=%h d=%0d e=%0d done@%0d err@%0d re=%0d wdata=%h ended=%0d",
             txn, tag, v.st, v.a, v.d, v.e, done_c, err_c, re_c, wd, ended);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = '{32'h0000_1001, 32'hFFFF_AAFF, 2'b01, 32'h1122_3344, 0, 0,  3, 0, 1, 1'b1, 32'h1122_AA44};
    tbl[1] = '{32'h0000_2002, 32'hBEEF_0000, 2'b10, 32'h1122_3344, 0, 0,  3, 0, 1, 1'b1, 32'hBEEF_3344};
    tbl[2] = '{32'h0000_3000, 32'hDEAD_BEEF, 2'b00, 32'h5555_5555, 0, 0,  1, 0, 0, 1'b1, 32'hDEAD_BEEF};
    tbl[3] = '{32'h0000_0010, 32'h0000_0077, 2'b01, 32'h1234_5678, 99, 0, 0, 5, 5, 1'b0, 32'h0};
    tbl[4] = '{32'h0000_0002, 32'h0055_0000, 2'b01, 32'hAABB_CCDD, 4, 0,  7, 0, 5, 1'b1, 32'hAA55_CCDD};
    tbl[5] = '{32'h0000_4000, 32'h0102_0304, 2'b00, 32'h0,         0, 99, 0, 5, 0, 1'b1, 32'h0102_0304};
    tbl[6] = '{32'h0000_4004, 32'h0A0B_0C0D, 2'b00, 32'h0,         0, 4,  5, 0, 0, 1'b1, 32'h0A0B_0C0D};
`ifdef MISALIGN_TRAP_EN
    tbl[7] = '{32'h0000_0003, 32'hCAFE_0000, 2'b10, 32'h1122_3344, 0, 0,  0, 1, 0, 1'b0, 32'h0};
`else
    tbl[7] = '{32'h0000_0003, 32'hCAFE_0000, 2'b10, 32'h1122_3344, 0, 0,  3, 0, 1, 1'b1, 32'hCAFE_3344};
`endif
    tbl[8] = '{32'h0000_5000, 32'h0000_ABCD, 2'b11, 32'h9988_7766, 1, 99, 0, 8, 2, 1'b1, 32'h9988_ABCD};

    reset = 1'b1; req_valid = 1'b0; Addr = '0; rd2 = '0; StoreType = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset mem_re",    32'(mem_re),    32'd0);
    chk("reset mem_we",    32'(mem_we),    32'd0);
    chk("reset done_err",  32'({done, err}), 32'd0);
    chk("reset mem_addr",  mem_addr,  32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);

    for (int i = 0; i < 9; i++) run_check(tbl[i], $sformatf("tbl%0d", i));

    // Stray handshakes while idle must not produce done/err or a memory access.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_rvalid = 1'b1; mem_ack = 1'b1;
      #1 chk("stray idle", 32'({done, err, mem_re, mem_we}), 32'd0);
    end
    @(negedge clk);
    mem_rvalid = 1'b0; mem_ack = 1'b0;
    $display("txn stray-handshake idle sequence done");

    // Reset while waiting in READ, with a request presented during reset.
    @(negedge clk);
    req_valid = 1'b1; Addr = 32'h0000_6001; rd2 = 32'h0000_1100; StoreType = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("rstrd in_read", 32'(mem_re), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; StoreType = 2'b00; Addr = 32'h0000_7000;
    #1 chk("rstrd pulses_in_reset", 32'({done, err}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("rstrd after_edge", 32'({mem_re, mem_we, done, err}), 32'd0);
    chk("rstrd ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1 chk("rstrd no_accept", 32'({mem_re, mem_we, done, err}), 32'd0);
    $display("txn reset-in-read sequence done");
    rv = '{32'h0000_7000, 32'h1357_9BDF, 2'b00, 32'h0, 0, 1, 2, 0, 0, 1'b1, 32'h1357_9BDF};
    run_check(rv, "post_reset_word");

    for (int i = 0; i < 40; i++) begin
      rv.a     = $urandom;
      rv.d32   = $urandom;
      rv.st    = 2'($urandom_range(0, 3));
      rv.rdata = $urandom;
      rv.d     = $urandom_range(0, 6);
      rv.e     = $urandom_range(0, 6);
      rv = model(rv);
      run_check(rv, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
